vlsu_mem_order_guard: RTL and testbench

//  Sits between the VLSU address generator and the AXI cut and gates AR/AW issue.

---
 rtl/vlsu_mem_order_guard.sv | 207 ++++++++++++++++++++
 tb/tb_vlsu_mem_order_guard.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vlsu_mem_order_guard.sv
// VLSU memory-order guard: gates AR/AW issue on outstanding counts, store-page hazards and a drain/flush FSM.
// Optional perf counters under VLSU_ORDER_GUARD_PERF_EN.
module vlsu_mem_order_guard #(
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned MaxRdTxn     = 8,
    parameter int unsigned MaxWrTxn     = 4,
    parameter int unsigned PageBits     = 12
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [1:0]              mode_i,
    input  logic                    core_st_pending_i,
    input  logic [AxiAddrWidth-1:0] ar_addr_i,
    input  logic                    ar_valid_i,
    output logic                    ar_ready_o,
    output logic                    ar_valid_o,
    input  logic                    ar_ready_i,
    input  logic [AxiAddrWidth-1:0] aw_addr_i,
    input  logic                    aw_valid_i,
    output logic                    aw_ready_o,
    output logic                    aw_valid_o,
    input  logic                    aw_ready_i,
    input  logic                    r_valid_i,
    input  logic                    r_ready_i,
    input  logic                    r_last_i,
    input  logic                    b_valid_i,
    input  logic                    b_ready_i,
    input  logic                    flush_req_i,
    output logic                    flush_done_o,
    output logic                    store_pending_o,
    output logic                    load_pending_o,
    output logic                    err_o
`ifdef VLSU_ORDER_GUARD_PERF_EN
    ,
    output logic [31:0]             ar_hazard_stall_cnt_o,
    output logic [31:0]             aw_full_stall_cnt_o
`endif
);

    // state | meaning
    // RUN   | normal operation, AR/AW issue allowed subject to limits and hazards
    // DRAIN | no new AR/AW, waiting for all outstanding reads and writes to retire

    localparam int unsigned RdCntW = $clog2(MaxRdTxn + 1);
    localparam int unsigned WrCntW = $clog2(MaxWrTxn + 1);
    localparam int unsigned PtrW   = (MaxWrTxn > 1) ? $clog2(MaxWrTxn) : 1;
    localparam int unsigned PageW  = AxiAddrWidth - PageBits;

    localparam logic [RdCntW-1:0] RdMax   = RdCntW'(MaxRdTxn);
    localparam logic [WrCntW-1:0] WrMax   = WrCntW'(MaxWrTxn);
    localparam logic [PtrW-1:0]   PtrLast = PtrW'(MaxWrTxn - 1);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [RdCntW-1:0]   rd_cnt;
    logic [WrCntW-1:0]   wr_cnt;
    logic [PtrW-1:0]     wr_ptr, rd_ptr;
    logic [PageW-1:0]    page_q [MaxWrTxn];
    logic [MaxWrTxn-1:0] page_vld;

    logic run, idle, flush_done_d;
    logic rd_not_full, wr_not_full;
    logic page_hit, hazard, ar_ok, aw_ok;
    logic ar_fire, aw_fire, r_done, b_done, pop;
    logic rd_err, wr_err;

    assign idle        = (rd_cnt == '0) && (wr_cnt == '0);
    assign rd_not_full = rd_cnt < RdMax;
    assign wr_not_full = wr_cnt < WrMax;

    // Compare uses registered entries only, so a store pushed this cycle is not yet visible.
    always_comb begin
        page_hit = 1'b0;
        for (int i = 0; i < int'(MaxWrTxn); i++) begin
            if (page_vld[i] && (page_q[i] == ar_addr_i[AxiAddrWidth-1:PageBits])) begin
                page_hit = 1'b1;
            end
        end
    end

    always_comb begin
        case (mode_i)
            2'd0:    hazard = 1'b0;
            2'd1:    hazard = core_st_pending_i | page_hit;
            default: hazard = core_st_pending_i | (wr_cnt != '0);
        endcase
    end

    assign ar_ok = run & rd_not_full & ~hazard;
    assign aw_ok = run & wr_not_full;

    assign ar_valid_o = ar_valid_i & ar_ok;
    assign ar_ready_o = ar_ready_i & ar_ok;
    assign aw_valid_o = aw_valid_i & aw_ok;
    assign aw_ready_o = aw_ready_i & aw_ok;

    assign ar_fire = ar_valid_i & ar_ready_i & ar_ok;
    assign aw_fire = aw_valid_i & aw_ready_i & aw_ok;
    assign r_done  = r_valid_i & r_ready_i & r_last_i;
    assign b_done  = b_valid_i & b_ready_i;
    assign pop     = b_done & ((wr_cnt != '0) | aw_fire);
    assign rd_err  = r_done & ~ar_fire & (rd_cnt == '0);
    assign wr_err  = b_done & ~aw_fire & (wr_cnt == '0);

    assign store_pending_o = (wr_cnt != '0);
    assign load_pending_o  = (rd_cnt != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush_req_i) state_d = DRAIN;
            DRAIN:   if (idle)        state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        run          = (state_q == RUN);
        flush_done_d = (state_q == DRAIN) && idle;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt       <= '0;
            wr_cnt       <= '0;
            err_o        <= 1'b0;
            flush_done_o <= 1'b0;
        end else begin
            flush_done_o <= flush_done_d;
            if (rd_err || wr_err) begin
                err_o <= 1'b1;
            end
            if (ar_fire && !r_done) begin
                rd_cnt <= rd_cnt + 1'b1;
            end else if (!ar_fire && r_done && (rd_cnt != '0)) begin
                rd_cnt <= rd_cnt - 1'b1;
            end
            if (aw_fire && !b_done) begin
                wr_cnt <= wr_cnt + 1'b1;
            end else if (!aw_fire && b_done && (wr_cnt != '0)) begin
                wr_cnt <= wr_cnt - 1'b1;
            end
        end
    end

    // Pop is applied after push so a same-slot push+pop on an empty FIFO leaves it empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            page_vld <= '0;
        end else begin
            if (aw_fire) begin
                page_vld[wr_ptr] <= 1'b1;
                wr_ptr           <= (wr_ptr == PtrLast) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                page_vld[rd_ptr] <= 1'b0;
                rd_ptr           <= (rd_ptr == PtrLast) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (aw_fire) begin
            page_q[wr_ptr] <= aw_addr_i[AxiAddrWidth-1:PageBits];
        end
    end

`ifdef VLSU_ORDER_GUARD_PERF_EN
    logic ar_hazard_stall, aw_full_stall;

    assign ar_hazard_stall = ar_valid_i & run & hazard;
    assign aw_full_stall   = aw_valid_i & run & ~wr_not_full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ar_hazard_stall_cnt_o <= '0;
            aw_full_stall_cnt_o   <= '0;
        end else if (flush_done_o) begin
            ar_hazard_stall_cnt_o <= '0;
            aw_full_stall_cnt_o   <= '0;
        end else begin
            if (ar_hazard_stall && (ar_hazard_stall_cnt_o != '1)) begin
                ar_hazard_stall_cnt_o <= ar_hazard_stall_cnt_o + 1'b1;
            end
            if (aw_full_stall && (aw_full_stall_cnt_o != '1)) begin
                aw_full_stall_cnt_o <= aw_full_stall_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vlsu_mem_order_guard.sv
// Directed bench for vlsu_mem_order_guard: a per-cycle vector table plus hand-written multi-cycle sequences.
// Perf counter checks compile only with VLSU_ORDER_GUARD_PERF_EN.
module tb_vlsu_mem_order_guard;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  mode_i;
    logic        core_st_pending_i;
    logic [63:0] ar_addr_i, aw_addr_i;
    logic        ar_valid_i, ar_ready_i, aw_valid_i, aw_ready_i;
    logic        ar_ready_o, ar_valid_o, aw_ready_o, aw_valid_o;
    logic        r_valid_i, r_ready_i, r_last_i, b_valid_i, b_ready_i;
    logic        flush_req_i, flush_done_o, store_pending_o, load_pending_o, err_o;
`ifdef VLSU_ORDER_GUARD_PERF_EN
    logic [31:0] ar_hazard_stall_cnt_o, aw_full_stall_cnt_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    vlsu_mem_order_guard #(
        .AxiAddrWidth(64), .MaxRdTxn(8), .MaxWrTxn(4), .PageBits(12)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .mode_i(mode_i), .core_st_pending_i(core_st_pending_i),
        .ar_addr_i(ar_addr_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .aw_addr_i(aw_addr_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
        .b_valid_i(b_valid_i), .b_ready_i(b_ready_i),
        .flush_req_i(flush_req_i), .flush_done_o(flush_done_o),
        .store_pending_o(store_pending_o), .load_pending_o(load_pending_o), .err_o(err_o)
`ifdef VLSU_ORDER_GUARD_PERF_EN
        , .ar_hazard_stall_cnt_o(ar_hazard_stall_cnt_o), .aw_full_stall_cnt_o(aw_full_stall_cnt_o)
`endif
    );

    // {ar_valid_o, ar_ready_o, aw_valid_o, aw_ready_o, store_pending_o, load_pending_o, err_o, flush_done_o}
    logic [7:0] obs;
    assign obs = {ar_valid_o, ar_ready_o, aw_valid_o, aw_ready_o,
                  store_pending_o, load_pending_o, err_o, flush_done_o};

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic        st;
        logic        arv;
        logic [63:0] ara;
        logic        awv;
        logic [63:0] awa;
        logic        rl;
        logic        b;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string n, logic [1:0] m, logic st, logic arv, logic [63:0] ara,
                                logic awv, logic [63:0] awa, logic rl, logic b, logic [7:0] exp);
        vec_t v;
        v.name = n; v.mode = m; v.st = st; v.arv = arv; v.ara = ara;
        v.awv = awv; v.awa = awa; v.rl = rl; v.b = b; v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    task automatic drive(logic [1:0] m, logic st, logic arv, logic [63:0] ara,
                         logic awv, logic [63:0] awa, logic rl, logic b, logic fl);
        mode_i = m; core_st_pending_i = st;
        ar_valid_i = arv; ar_addr_i = ara; ar_ready_i = 1'b1;
        aw_valid_i = awv; aw_addr_i = awa; aw_ready_i = 1'b1;
        r_valid_i = rl; r_ready_i = rl; r_last_i = rl;
        b_valid_i = b; b_ready_i = b;
        flush_req_i = fl;
    endtask

    task automatic all_low();
        drive(2'd0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        ar_ready_i = 1'b0;
        aw_ready_i = 1'b0;
    endtask

    task automatic next_cyc();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        all_low();
        rst_ni = 1'b0;
        #12;
        chk("reset_outputs", 32'(obs), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        next_cyc();

        // page-check ordering
        add("m1_idle",       2'd1, 0, 0, 64'h0,    0, 64'h0,    0, 0, 8'b0101_0000);
        add("m1_aw_1000",    2'd1, 0, 0, 64'h0,    1, 64'h1000, 0, 0, 8'b0111_0000);
        add("m1_ar_1ff8_blk",2'd1, 0, 1, 64'h1ff8, 0, 64'h0,    0, 0, 8'b0001_1000);
        add("m1_ar_2000_ok", 2'd1, 0, 1, 64'h2000, 0, 64'h0,    0, 0, 8'b1101_1000);
        add("m1_b_same_cyc", 2'd1, 0, 1, 64'h1ff8, 0, 64'h0,    0, 1, 8'b0001_1100);
        add("m1_ar_1ff8_ok", 2'd1, 0, 1, 64'h1ff8, 0, 64'h0,    0, 0, 8'b1101_0100);
        add("m1_rlast_a",    2'd1, 0, 0, 64'h0,    0, 64'h0,    1, 0, 8'b0101_0100);
        add("m1_rlast_b",    2'd1, 0, 0, 64'h0,    0, 64'h0,    1, 0, 8'b0101_0100);
        add("m1_drained",    2'd1, 0, 0, 64'h0,    0, 64'h0,    0, 0, 8'b0101_0000);
        add("m1_core_st_blk",2'd1, 1, 1, 64'h7000, 0, 64'h0,    0, 0, 8'b0001_0000);
        add("m0_core_st_ok", 2'd0, 1, 1, 64'h7000, 0, 64'h0,    0, 0, 8'b1101_0000);
        add("m0_rlast",      2'd0, 0, 0, 64'h0,    0, 64'h0,    1, 0, 8'b0101_0100);
        add("m0_idle",       2'd0, 0, 0, 64'h0,    0, 64'h0,    0, 0, 8'b0101_0000);
        // strict mode, write FIFO full
        add("m2_aw1",        2'd2, 0, 0, 64'h0,    1, 64'h3000, 0, 0, 8'b0111_0000);
        add("m2_aw2",        2'd2, 0, 0, 64'h0,    1, 64'h3040, 0, 0, 8'b0011_1000);
        add("m2_aw3",        2'd2, 0, 0, 64'h0,    1, 64'h4000, 0, 0, 8'b0011_1000);
        add("m2_aw4",        2'd2, 0, 0, 64'h0,    1, 64'h5000, 0, 0, 8'b0011_1000);
        add("m2_aw5_full",   2'd2, 0, 1, 64'h9000, 1, 64'h6000, 0, 0, 8'b0000_1000);
        add("m2_b1_full",    2'd2, 0, 1, 64'h9000, 1, 64'h6000, 0, 1, 8'b0000_1000);
        add("m2_aw5_pass",   2'd2, 0, 1, 64'h9000, 1, 64'h6000, 0, 0, 8'b0011_1000);
        add("m3_b_full",     2'd3, 0, 1, 64'h9000, 0, 64'h0,    0, 1, 8'b0000_1000);
        add("m3_b_3",        2'd3, 0, 1, 64'h9000, 0, 64'h0,    0, 1, 8'b0001_1000);
        add("m3_b_2",        2'd3, 0, 1, 64'h9000, 0, 64'h0,    0, 1, 8'b0001_1000);
        add("m3_b_last",     2'd3, 0, 1, 64'h9000, 0, 64'h0,    0, 1, 8'b0001_1000);
        add("m3_ar_pass",    2'd3, 0, 1, 64'h9000, 0, 64'h0,    0, 0, 8'b1101_0000);
        add("m3_rlast",      2'd3, 0, 0, 64'h0,    0, 64'h0,    1, 0, 8'b0101_0100);
        add("m3_idle",       2'd3, 0, 0, 64'h0,    0, 64'h0,    0, 0, 8'b0101_0000);

        foreach (vecs[i]) begin
            drive(vecs[i].mode, vecs[i].st, vecs[i].arv, vecs[i].ara,
                  vecs[i].awv, vecs[i].awa, vecs[i].rl, vecs[i].b, 1'b0);
            @(negedge clk_i);
            chk(vecs[i].name, 32'(obs), 32'(vecs[i].exp));
            next_cyc();
        end

        // read limit: 8 outstanding, 9th blocked, retire+issue in one cycle
        for (int i = 0; i < 8; i++) begin
            drive(2'd0, 0, 1, 64'h100, 0, 64'h0, 0, 0, 0);
            @(negedge clk_i);
            chk($sformatf("rd_issue_%0d", i), 32'(ar_valid_o), 32'h1);
            next_cyc();
        end
        @(negedge clk_i);
        chk("rd_9th_blocked", 32'(obs), 32'b1_0100 | 32'(8'b0001_0000));
        next_cyc();
        drive(2'd0, 0, 0, 64'h0, 0, 64'h0, 1, 0, 0);
        next_cyc();
        drive(2'd0, 0, 1, 64'h100, 0, 64'h0, 1, 0, 0);
        @(negedge clk_i);
        chk("rd_fire_and_retire", 32'(ar_valid_o), 32'h1);
        next_cyc();
        drive(2'd0, 0, 1, 64'h100, 0, 64'h0, 0, 0, 0);
        @(negedge clk_i);
        chk("rd_still_7", 32'(ar_valid_o), 32'h1);
        next_cyc();
        @(negedge clk_i);
        chk("rd_full_again", 32'(ar_valid_o), 32'h0);
        next_cyc();
        for (int i = 0; i < 8; i++) begin
            drive(2'd0, 0, 0, 64'h0, 0, 64'h0, 1, 0, 0);
            @(negedge clk_i);
            chk($sformatf("rd_retire_%0d", i), 32'(load_pending_o), 32'h1);
            next_cyc();
        end
        drive(2'd0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 0);
        @(negedge clk_i);
        chk("rd_all_retired", 32'(obs), 32'(8'b0101_0000));
        next_cyc();

        // drain with two reads outstanding
        drive(2'd0, 0, 1, 64'h200, 0, 64'h0, 0, 0, 0);
        next_cyc();
        next_cyc();
        drive(2'd0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 1);
        @(negedge clk_i);
        chk("fl_req_cycle", 32'(obs), 32'(8'b0101_0100));
        next_cyc();
        drive(2'd0, 0, 1, 64'h200, 1, 64'h8000, 0, 0, 1);
        @(negedge clk_i);
        chk("fl_drain_blocks", 32'(obs), 32'(8'b0000_0100));
        next_cyc();
        drive(2'd0, 0, 1, 64'h200, 1, 64'h8000, 1, 0, 0);
        @(negedge clk_i);
        chk("fl_rlast_1", 32'(obs), 32'(8'b0000_0100));
        next_cyc();
        drive(2'd0, 0, 1, 64'h200, 1, 64'h8000, 1, 0, 0);
        @(negedge clk_i);
        chk("fl_rlast_2", 32'(obs), 32'(8'b0000_0100));
        next_cyc();
        drive(2'd0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 0);
        @(negedge clk_i);
        chk("fl_drain_idle", 32'(obs), 32'h0);
        next_cyc();
        @(negedge clk_i);
        chk("fl_done_pulse", 32'(obs), 32'(8'b0101_0001));
        next_cyc();
        @(negedge clk_i);
        chk("fl_done_cleared", 32'(obs), 32'(8'b0101_0000));
        next_cyc();

        // flush while already idle
        drive(2'd0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 1);
        next_cyc();
        drive(2'd0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 0);
        @(negedge clk_i);
        chk("fl_idle_drain", 32'(obs), 32'h0);
        next_cyc();
        @(negedge clk_i);
        chk("fl_idle_pulse", 32'(obs), 32'(8'b0101_0001));
        next_cyc();
        @(negedge clk_i);
        chk("fl_idle_after", 32'(obs), 32'(8'b0101_0000));
        next_cyc();

        // B with nothing outstanding, then reset mid-stream
        drive(2'd0, 0, 0, 64'h0, 0, 64'h0, 0, 1, 0);
        next_cyc();
        drive(2'd0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 0);
        @(negedge clk_i);
        chk("err_sticky_set", 32'(obs), 32'(8'b0101_0010));
        next_cyc();
        drive(2'd0, 0, 0, 64'h0, 1, 64'h4000, 0, 0, 0);
        next_cyc();
        drive(2'd2, 0, 1, 64'ha000, 0, 64'h0, 0, 0, 0);
        @(negedge clk_i);
        chk("err_with_store", 32'(obs), 32'(8'b0001_1010));
        all_low();
        rst_ni = 1'b0;
        #1;
        chk("mid_reset_outputs", 32'(obs), 32'h0);
        next_cyc();
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(2'd2, 0, 0, 64'h0, 0, 64'h0, 0, 0, 0);
        next_cyc();
        @(negedge clk_i);
        chk("post_reset_clean", 32'(obs), 32'(8'b0101_0000));
        next_cyc();

`ifdef VLSU_ORDER_GUARD_PERF_EN
        drive(2'd2, 0, 0, 64'h0, 1, 64'hb000, 0, 0, 0);
        next_cyc();
        for (int i = 0; i < 5; i++) begin
            drive(2'd2, 0, 1, 64'hc000, 0, 64'h0, 0, 0, 0);
            next_cyc();
        end
        drive(2'd2, 0, 0, 64'h0, 0, 64'h0, 0, 0, 0);
        @(negedge clk_i);
        chk("perf_ar_hazard", ar_hazard_stall_cnt_o, 32'd5);
        chk("perf_aw_full", aw_full_stall_cnt_o, 32'd0);
        next_cyc();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
